// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Instruction fetch / execute / memory FSM. Owns the program counter and the
// instruction register and issues the datapath control word each cycle.
// The control word is decoded combinationally from the current state and IR.
//
// Ports:
//   clock_50   : system clock, rising edge
//   clear      : asynchronous reset, active-low
//   run        : level enable, a FETCH only proceeds while high
//   mem_data   : instruction/data word from memory (combinational read)
//   PS         : datapath status, 1 = F is zero
//   Cout       : datapath carry out
//   PC         : instruction address
//   IR_L       : instruction-load strobe
//   WR         : register-file write enable
//   DA/AA/BA   : destination / A / B register addresses
//   FS, Cin, k : function select, ALU carry in, constant operand
//   MA         : 1 = memory address from datapath A bus, 0 = from PC
//   MD         : 1 = register write data from memory
//   MW         : memory write strobe
//   carry_flag : Cout captured on the last ALU reg-reg write
//   halted     : high in HALT state
// -----------------------------------------------------------------------------
module control_sequencer #(
   parameter int         PC_W     = 16,
   parameter logic [4:0] FS_PASSA = 5'b00000,
   parameter logic [4:0] FS_LOADK = 5'b01111
) (
   input  logic            clock_50,
   input  logic            clear,
   input  logic            run,
   input  logic [15:0]     mem_data,
   input  logic            PS,
   input  logic            Cout,
   output logic [PC_W-1:0] PC,
   output logic            IR_L,
   output logic            WR,
   output logic [2:0]      DA,
   output logic [2:0]      AA,
   output logic [2:0]      BA,
   output logic [4:0]      FS,
   output logic            Cin,
   output logic [15:0]     k,
   output logic            MA,
   output logic            MD,
   output logic            MW,
   output logic            carry_flag,
   output logic            halted
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_MEM   = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b10000;
   localparam logic [4:0] OP_ST   = 5'b10001;
   localparam logic [4:0] OP_LDI  = 5'b10010;
   localparam logic [4:0] OP_BZ   = 5'b10011;
   localparam logic [4:0] OP_BR   = 5'b10100;
   localparam logic [4:0] OP_HALT = 5'b11111;

   state_t          state_r;
   logic [PC_W-1:0] pc_r;
   logic [15:0]     ir_r;
   logic            carry_flag_r;

   logic [4:0]      op_s;
   logic [15:0]     ksx_s;
   logic [PC_W-1:0] off6_s;

   assign op_s   = ir_r[15:11];
   assign ksx_s  = {{11{ir_r[4]}}, ir_r[4:0]};
   // Branch offset is split around the AA field: {IR[10:8], IR[4:2]}.
   assign off6_s = {{(PC_W-6){ir_r[10]}}, ir_r[10:8], ir_r[4:2]};

   assign PC         = pc_r;
   assign carry_flag = carry_flag_r;

   // State, PC, IR and carry flag sequencing.
   always_ff @(posedge clock_50 or negedge clear) begin
      if (!clear) begin
         state_r      <= ST_FETCH;
         pc_r         <= {PC_W{1'b0}};
         ir_r         <= 16'h0000;
         carry_flag_r <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (run) begin
                  ir_r    <= mem_data;
                  pc_r    <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                  state_r <= ST_EXEC;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_EXEC: begin
               if (!op_s[4]) begin
                  carry_flag_r <= Cout;
                  state_r      <= ST_FETCH;
               end else begin
                  case (op_s)
                     OP_LD, OP_ST: state_r <= ST_MEM;
                     OP_BZ: begin
                        // PC already points past the branch; wraps mod 2^PC_W.
                        if (PS) begin
                           pc_r <= pc_r + off6_s;
                        end else begin
                           pc_r <= pc_r;
                        end
                        state_r <= ST_FETCH;
                     end
                     OP_BR: begin
                        pc_r    <= pc_r + off6_s;
                        state_r <= ST_FETCH;
                     end
                     OP_HALT: state_r <= ST_HALT;
                     default: state_r <= ST_FETCH;
                  endcase
               end
            end
            ST_MEM:  state_r <= ST_FETCH;
            ST_HALT: state_r <= ST_HALT;
            default: state_r <= ST_FETCH;
         endcase
      end
   end

   // Control-word decode from state and IR.
   always_comb begin
      IR_L   = 1'b0;
      WR     = 1'b0;
      DA     = 3'd0;
      AA     = 3'd0;
      BA     = 3'd0;
      FS     = 5'b00000;
      Cin    = 1'b0;
      k      = 16'h0000;
      MA     = 1'b0;
      MD     = 1'b0;
      MW     = 1'b0;
      halted = 1'b0;
      case (state_r)
         ST_FETCH: begin
            // Gated by clear so every strobe is low while reset is held.
            IR_L = run & clear;
         end
         ST_EXEC: begin
            DA = ir_r[10:8];
            AA = ir_r[7:5];
            BA = ir_r[4:2];
            if (!op_s[4]) begin
               FS  = op_s;
               Cin = ir_r[0];
               WR  = 1'b1;
            end else begin
               case (op_s)
                  OP_LD, OP_ST: MA = 1'b1;
                  OP_LDI: begin
                     FS = FS_LOADK;
                     k  = ksx_s;
                     WR = 1'b1;
                  end
                  OP_BZ:   FS = FS_PASSA;
                  default: FS = 5'b00000;
               endcase
            end
         end
         ST_MEM: begin
            DA = ir_r[10:8];
            AA = ir_r[7:5];
            BA = ir_r[4:2];
            MA = 1'b1;
            if (op_s == OP_LD) begin
               MD = 1'b1;
               WR = 1'b1;
            end else begin
               MW = 1'b1;
            end
         end
         ST_HALT: halted = 1'b1;
         default: halted = 1'b0;
      endcase
   end

endmodule
